data_mem_responder: RTL

- Data-memory end of the load/store interface: responds to the readmem/writemem strobes issued by the main control decoder.
- Holds a word-addressed RAM with fixed multi-cycle access latency.
- Asserts stall to freeze the pipeline while an access is in flight, then pulses ready.
- Checks word alignment and flags bad requests without touching memory.

---
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory end of the load/store interface.
// Word-addressed RAM with a fixed multi-cycle access latency. stall freezes
// the pipeline while an access is in flight; ready pulses on completion.
// Misaligned or conflicting requests are rejected with an addr_err pulse and
// never touch memory.
// Optional build macro: DMEM_BYTE_WRITE_EN adds a byte_en[3:0] input for
// byte-lane stores.
//
// state | meaning
// IDLE  | waiting for a request; accepts or rejects in this cycle
// BUSY  | access in flight, counter running down, stall held high
// DONE  | access completed this cycle, ready high, back to IDLE next
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  readmem,
    input  logic                  writemem,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [3:0]            byte_en,
`endif
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  stall,
    output logic                  addr_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state;
    logic [2:0]              cnt;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic                    lat_write;
    logic [3:0]              lat_be;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic                    req;
    logic                    aligned;
    logic                    be_bad;
    logic                    accept;
    logic                    reject;
    logic                    commit;
    logic [3:0]              be_in;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    acc_write;
    logic [3:0]              acc_be;

    // Upper address bits alias; they are deliberately not decoded.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

`ifdef DMEM_BYTE_WRITE_EN
    assign be_in = byte_en;
`else
    assign be_in = 4'hF;
`endif

    // Request classification in IDLE: accept, reject, or nothing.
    always_comb begin
        req     = readmem ^ writemem;
        aligned = (addr[1:0] == 2'b00);
        be_bad  = 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
        // Single-lane stores may sit at any byte offset within the word.
        if (writemem && (byte_en == 4'b0001 || byte_en == 4'b0010 ||
                         byte_en == 4'b0100 || byte_en == 4'b1000))
            aligned = 1'b1;
        be_bad = writemem && (byte_en == 4'b0000);
`endif
        accept = (state == IDLE) && req && aligned && !be_bad;
        reject = (state == IDLE) && ((readmem && writemem) ||
                                     (req && !(aligned && !be_bad)));
    end

    // Access operands: live inputs when completing straight from IDLE,
    // latched copies otherwise.
    always_comb begin
        if (state == IDLE) begin
            acc_idx   = addr[ADDR_WIDTH+1:2];
            acc_wdata = wdata;
            acc_write = writemem;
            acc_be    = be_in;
        end else begin
            acc_idx   = lat_idx;
            acc_wdata = lat_wdata;
            acc_write = lat_write;
            acc_be    = lat_be;
        end
        // The memory access happens on the edge that enters DONE, so rdata
        // is already valid when ready rises.
        commit = !rst && ((accept && (LATENCY == 1)) ||
                          ((state == BUSY) && (cnt == 3'd1)));
    end

    assign stall = accept || (state == BUSY);

    // RAM store port; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && acc_write) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i])
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // Control FSM with registered completion/error pulses and load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            lat_be    <= 4'h0;
            rdata     <= '0;
            ready     <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            ready    <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_idx   <= addr[ADDR_WIDTH+1:2];
                        lat_wdata <= wdata;
                        lat_write <= writemem;
                        lat_be    <= be_in;
                        cnt       <= 3'(LATENCY - 1);
                        state     <= (LATENCY > 1) ? BUSY : DONE;
                    end else if (reject) begin
                        ready    <= 1'b1;
                        addr_err <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (commit) begin
                ready <= 1'b1;
                if (!acc_write)
                    rdata <= mem[acc_idx];
            end
        end
    end

endmodule
